// File: rtl/dac_sweep_ctrl_if.sv
// Control/config bus between the sweep configuration logic and the DDS sequencer.
// The master drives the start/stop pulses and sweep settings; the slave returns the status and ROM addresses.
interface dac_sweep_ctrl_if #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] cfg_start_fw;
    logic [PHASE_W-1:0] cfg_stop_fw;
    logic [PHASE_W-1:0] cfg_step_fw;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [PHASE_W-1:0] cfg_ch2_phase;
    logic               busy;
    logic               addr_valid;
    logic               sweep_done;
    logic [PHASE_W-1:0] cur_fw;
    logic [ADDR_W-1:0]  ch1_addr;
    logic [ADDR_W-1:0]  ch2_addr;

    modport master (
        output start, stop, cfg_start_fw, cfg_stop_fw, cfg_step_fw, cfg_dwell, cfg_ch2_phase,
        input  busy, addr_valid, sweep_done, cur_fw, ch1_addr, ch2_addr
    );

    modport slave (
        input  start, stop, cfg_start_fw, cfg_stop_fw, cfg_step_fw, cfg_dwell, cfg_ch2_phase,
        output busy, addr_valid, sweep_done, cur_fw, ch1_addr, ch2_addr
    );
endinterface

// File: rtl/dac_sweep_ctrl.sv
// Dual-channel DDS sequencer: stepped frequency sweep driving both sine-ROM address buses.
// Define DAC_SWEEP_BIDIR_EN for a triangle (up/down) sweep; the default build produces a sawtooth sweep.
module dac_sweep_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DWELL_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    dac_sweep_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_reg;
    logic [PHASE_W-1:0] start_fw_reg;
    logic [PHASE_W-1:0] stop_fw_reg;
    logic [PHASE_W-1:0] step_fw_reg;
    logic [PHASE_W-1:0] cur_fw_reg;
    logic [DWELL_W-1:0] dwell_last_reg;
    logic [DWELL_W-1:0] dwell_cnt_reg;
    logic               degenerate_reg;
    logic               busy_reg;
    logic               sweep_done_reg;

    logic                     load_start;
    logic                     dwell_end;
    logic [PHASE_W:0]         up_next;
    logic                     up_end;
    logic [DWELL_W-1:0]       dwell_last_next;
    logic [1:0][PHASE_W-1:0]  acc_init;
    logic [1:0][ADDR_W-1:0]   addr;

`ifdef DAC_SWEEP_BIDIR_EN
    logic             dir_down_reg;
    logic [PHASE_W:0] down_next;
    logic             down_end;

    // Bit PHASE_W of the extended difference flags an underflow below zero.
    assign down_next = {1'b0, cur_fw_reg} - {1'b0, step_fw_reg};
    assign down_end  = down_next[PHASE_W] || (down_next[PHASE_W-1:0] <= start_fw_reg);
`endif

    assign load_start      = (state_reg == IDLE) && bus.start && !bus.stop;
    assign dwell_end       = (dwell_cnt_reg == dwell_last_reg);
    assign up_next         = {1'b0, cur_fw_reg} + {1'b0, step_fw_reg};
    assign up_end          = (up_next >= {1'b0, stop_fw_reg});
    // A dwell of 0 behaves as 1, so a step is taken every clock.
    assign dwell_last_next = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - DWELL_W'(1);
    assign acc_init        = {bus.cfg_ch2_phase, {PHASE_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset || bus.stop) begin
            state_reg      <= IDLE;
            start_fw_reg   <= '0;
            stop_fw_reg    <= '0;
            step_fw_reg    <= '0;
            cur_fw_reg     <= '0;
            dwell_last_reg <= '0;
            dwell_cnt_reg  <= '0;
            degenerate_reg <= 1'b0;
            busy_reg       <= 1'b0;
            sweep_done_reg <= 1'b0;
`ifdef DAC_SWEEP_BIDIR_EN
            dir_down_reg   <= 1'b0;
`endif
        end else begin
            sweep_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        start_fw_reg   <= bus.cfg_start_fw;
                        stop_fw_reg    <= bus.cfg_stop_fw;
                        step_fw_reg    <= bus.cfg_step_fw;
                        dwell_last_reg <= dwell_last_next;
                        // Zero step or an empty range holds a single tone forever.
                        degenerate_reg <= (bus.cfg_step_fw == '0) ||
                                          (bus.cfg_start_fw >= bus.cfg_stop_fw);
                        cur_fw_reg     <= bus.cfg_start_fw;
                        dwell_cnt_reg  <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= RUN;
`ifdef DAC_SWEEP_BIDIR_EN
                        dir_down_reg   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (dwell_end) begin
                        dwell_cnt_reg <= '0;
                        if (!degenerate_reg) begin
`ifdef DAC_SWEEP_BIDIR_EN
                            if (dir_down_reg) begin
                                if (down_end) begin
                                    cur_fw_reg     <= start_fw_reg;
                                    dir_down_reg   <= 1'b0;
                                    sweep_done_reg <= 1'b1;
                                end else begin
                                    cur_fw_reg <= down_next[PHASE_W-1:0];
                                end
                            end else if (up_end) begin
                                cur_fw_reg     <= stop_fw_reg;
                                dir_down_reg   <= 1'b1;
                                sweep_done_reg <= 1'b1;
                            end else begin
                                cur_fw_reg <= up_next[PHASE_W-1:0];
                            end
`else
                            if (up_end) begin
                                cur_fw_reg     <= start_fw_reg;
                                sweep_done_reg <= 1'b1;
                            end else begin
                                cur_fw_reg <= up_next[PHASE_W-1:0];
                            end
`endif
                        end
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-channel phase accumulators; the ROM address is the top slice of each.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [PHASE_W-1:0] acc_reg;

            always_ff @(posedge clk) begin
                if (reset || bus.stop) begin
                    acc_reg <= '0;
                end else if (load_start) begin
                    acc_reg <= acc_init[gi];
                end else if (state_reg == RUN) begin
                    acc_reg <= acc_reg + cur_fw_reg;
                end else begin
                    acc_reg <= '0;
                end
            end

            assign addr[gi] = acc_reg[PHASE_W-1 -: ADDR_W];
        end
    endgenerate

    assign bus.busy       = busy_reg;
    assign bus.addr_valid = busy_reg;
    assign bus.sweep_done = sweep_done_reg;
    assign bus.cur_fw     = cur_fw_reg;
    assign bus.ch1_addr   = addr[0];
    assign bus.ch2_addr   = addr[1];
endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Self-checking bench for dac_sweep_ctrl: randomized and directed sweeps against a
// frequency-list reference model (sawtooth or triangle depending on DAC_SWEEP_BIDIR_EN).
module tb_dac_sweep_ctrl;
    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 10;
    localparam int DWELL_W = 16;
    localparam int OBS_W   = 3 + PHASE_W + 2 * ADDR_W;
    typedef logic [OBS_W-1:0] obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dac_sweep_ctrl_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) bus ();

    dac_sweep_ctrl #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the list of frequency words visited in one sweep period.
    logic [PHASE_W-1:0] fw_q[$];
    bit                 done_q[$];
    int                 model_d;
    int                 model_k;
    logic [PHASE_W-1:0] model_acc1;
    logic [PHASE_W-1:0] model_acc2;

    function automatic void model_start(input logic [PHASE_W-1:0] s_fw, input logic [PHASE_W-1:0] e_fw,
                                        input logic [PHASE_W-1:0] st, input int dwell,
                                        input logic [PHASE_W-1:0] ph);
        logic [PHASE_W:0] v;
        fw_q.delete();
        done_q.delete();
        model_d    = (dwell == 0) ? 1 : dwell;
        model_k    = 0;
        model_acc1 = '0;
        model_acc2 = ph;
        if (st == 0 || s_fw >= e_fw) begin
            fw_q.push_back(s_fw);
            done_q.push_back(1'b0);
        end else begin
            v = {1'b0, s_fw};
            while (v < {1'b0, e_fw}) begin
                fw_q.push_back(v[PHASE_W-1:0]);
                done_q.push_back(fw_q.size() == 1);
                v = v + {1'b0, st};
            end
`ifdef DAC_SWEEP_BIDIR_EN
            fw_q.push_back(e_fw);
            done_q.push_back(1'b1);
            v = {1'b0, e_fw};
            while (!(v < {1'b0, st} || (v - {1'b0, st}) <= {1'b0, s_fw})) begin
                v = v - {1'b0, st};
                fw_q.push_back(v[PHASE_W-1:0]);
                done_q.push_back(1'b0);
            end
`endif
        end
    endfunction

    function automatic obs_t model_next();
        int                 idx;
        logic [PHASE_W-1:0] fw;
        bit                 dn;
        idx = (model_k / model_d) % fw_q.size();
        fw  = fw_q[idx];
        dn  = (model_k > 0) && ((model_k % model_d) == 0) && done_q[idx];
        model_next = {1'b1, 1'b1, dn, fw, model_acc1[PHASE_W-1 -: ADDR_W], model_acc2[PHASE_W-1 -: ADDR_W]};
        model_acc1 = model_acc1 + fw;
        model_acc2 = model_acc2 + fw;
        model_k++;
    endfunction

    function automatic obs_t observe();
        return {bus.busy, bus.addr_valid, bus.sweep_done, bus.cur_fw, bus.ch1_addr, bus.ch2_addr};
    endfunction

    task automatic do_start(input logic [PHASE_W-1:0] s_fw, input logic [PHASE_W-1:0] e_fw,
                            input logic [PHASE_W-1:0] st, input int dwell, input logic [PHASE_W-1:0] ph);
        @(posedge clk); #1;
        bus.cfg_start_fw  = s_fw;
        bus.cfg_stop_fw   = e_fw;
        bus.cfg_step_fw   = st;
        bus.cfg_dwell     = DWELL_W'(dwell);
        bus.cfg_ch2_phase = ph;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start         = 1'b0;
        // Scramble the config to confirm it was captured at start.
        bus.cfg_start_fw  = $urandom;
        bus.cfg_stop_fw   = $urandom;
        bus.cfg_step_fw   = $urandom;
        bus.cfg_dwell     = DWELL_W'($urandom);
        bus.cfg_ch2_phase = $urandom;
        model_start(s_fw, e_fw, st, dwell, ph);
    endtask

    task automatic do_stop();
        @(posedge clk); #1;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fails++;
            $display("FAIL reset_state obs=%h exp=%h", o, obs_t'(0));
        end
        $display("reset: outputs=%h", o);
    endtask

    task automatic test_tone();
        obs_t o, e;
        do_start(32'h0040_0000, 32'h8000_0000, 32'h0, 4, 32'h0);
        for (int k = 0; k < 1030; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL tone k=%0d obs=%h exp=%h", k, o, e);
            end
            n_checks++;
            if (bus.ch1_addr !== ADDR_W'(k % 1024)) begin
                n_fails++;
                $display("FAIL tone_addr k=%0d obs=%0d exp=%0d", k, bus.ch1_addr, k % 1024);
            end
        end
        $display("tone: 1030 cycles, ch1_addr=%0d", bus.ch1_addr);
        do_stop();
    endtask

    task automatic test_ch2_offset();
        obs_t               o, e;
        logic [ADDR_W-1:0]  want2;
        do_start(32'h0040_0000, 32'h8000_0000, 32'h0, 4, 32'h4000_0000);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            o     = observe();
            e     = model_next();
            want2 = bus.ch1_addr + ADDR_W'(256);
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL ch2_model k=%0d obs=%h exp=%h", k, o, e);
            end
            n_checks++;
            if (bus.ch2_addr !== want2) begin
                n_fails++;
                $display("FAIL ch2_offset k=%0d obs=%0d exp=%0d", k, bus.ch2_addr, want2);
            end
        end
        $display("ch2_offset: ch1=%0d ch2=%0d", bus.ch1_addr, bus.ch2_addr);
        do_stop();
        @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fails++;
            $display("FAIL stop_mid obs=%h exp=%h", o, obs_t'(0));
        end
        $display("stop_mid: outputs=%h", o);
    endtask

    task automatic test_sweep_profile();
        obs_t               o, e;
        logic [PHASE_W-1:0] fw9;
`ifdef DAC_SWEEP_BIDIR_EN
        fw9 = 32'h400;
`else
        fw9 = 32'h100;
`endif
        do_start(32'h100, 32'h400, 32'h100, 3, 32'h0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL profile k=%0d obs=%h exp=%h", k, o, e);
            end
            if (k == 9) begin
                n_checks++;
                if (bus.cur_fw !== fw9 || bus.sweep_done !== 1'b1) begin
                    n_fails++;
                    $display("FAIL profile_endpoint cur_fw=%h done=%b exp_fw=%h exp_done=1", bus.cur_fw, bus.sweep_done, fw9);
                end
            end
        end
        $display("profile: 60 cycles, cur_fw=%h", bus.cur_fw);
        do_stop();
    endtask

    task automatic test_dwell0();
        obs_t o, e;
        do_start(32'h100, 32'h800, 32'h100, 0, 32'h1234_5678);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL dwell0 k=%0d obs=%h exp=%h", k, o, e);
            end
            if (k == 1) begin
                n_checks++;
                if (bus.cur_fw !== 32'h200) begin
                    n_fails++;
                    $display("FAIL dwell0_step cur_fw=%h exp=%h", bus.cur_fw, 32'h200);
                end
            end
        end
        $display("dwell0: 40 cycles, cur_fw=%h", bus.cur_fw);
        do_stop();
    endtask

    task automatic test_degenerate();
        obs_t o, e;
        do_start(32'h500, 32'h400, 32'h100, 2, 32'h0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e || bus.cur_fw !== 32'h500 || bus.sweep_done !== 1'b0) begin
                n_fails++;
                $display("FAIL degenerate k=%0d obs=%h exp=%h", k, o, e);
            end
        end
        $display("degenerate: cur_fw=%h", bus.cur_fw);
        do_stop();
    endtask

    task automatic test_overflow();
        obs_t o, e;
        do_start(32'hF000_0000, 32'hFFFF_FFFF, 32'h1000_0000, 2, 32'h0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL overflow k=%0d obs=%h exp=%h", k, o, e);
            end
        end
        $display("overflow: cur_fw=%h", bus.cur_fw);
        do_stop();
    endtask

    task automatic test_start_stop_same();
        obs_t o;
        @(posedge clk); #1;
        bus.cfg_start_fw = 32'h100;
        bus.cfg_stop_fw  = 32'h400;
        bus.cfg_step_fw  = 32'h100;
        bus.cfg_dwell    = 16'd3;
        bus.start        = 1'b1;
        bus.stop         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            o = observe();
            n_checks++;
            if (o !== '0) begin
                n_fails++;
                $display("FAIL start_stop_same k=%0d obs=%h exp=%h", k, o, obs_t'(0));
            end
        end
        $display("start_stop_same: busy=%b", bus.busy);
    endtask

    task automatic test_start_in_run();
        obs_t o, e;
        do_start(32'h300, 32'h1000, 32'h200, 2, 32'h8000_0000);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL start_in_run k=%0d obs=%h exp=%h", k, o, e);
            end
            bus.start = (k == 10);
            if (k == 10) begin
                bus.cfg_start_fw = 32'h7777;
                bus.cfg_step_fw  = 32'h1;
            end
        end
        $display("start_in_run: cur_fw=%h", bus.cur_fw);
        do_stop();
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        do_start(32'h100, 32'h400, 32'h100, 3, 32'h4000_0000);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            o = observe();
            e = model_next();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL reset_mid_run k=%0d obs=%h exp=%h", k, o, e);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fails++;
            $display("FAIL reset_mid obs=%h exp=%h", o, obs_t'(0));
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_idle obs=%h exp=%h", o, obs_t'(0));
        end
        $display("reset_mid: outputs=%h", o);
    endtask

    task automatic test_random();
        obs_t               o, e;
        logic [PHASE_W-1:0] s_fw, e_fw, st, ph;
        int                 dw;
        for (int it = 0; it < 8; it++) begin
            s_fw = PHASE_W'($urandom_range(0, 'h2000));
            e_fw = ($urandom_range(0, 4) == 0) ? PHASE_W'($urandom_range(0, 'h2000))
                                               : s_fw + PHASE_W'($urandom_range(1, 'h2000));
            st   = ($urandom_range(0, 4) == 0) ? '0 : PHASE_W'($urandom_range('h100, 'h800));
            dw   = $urandom_range(0, 5);
            ph   = $urandom;
            do_start(s_fw, e_fw, st, dw, ph);
            for (int k = 0; k < 150; k++) begin
                @(negedge clk);
                o = observe();
                e = model_next();
                n_checks++;
                if (o !== e) begin
                    n_fails++;
                    $display("FAIL random it=%0d k=%0d obs=%h exp=%h", it, k, o, e);
                end
            end
            $display("random %0d: start=%h stop=%h step=%h dwell=%0d cur_fw=%h", it, s_fw, e_fw, st, dw, bus.cur_fw);
            do_stop();
            @(negedge clk);
            o = observe();
            n_checks++;
            if (o !== '0) begin
                n_fails++;
                $display("FAIL random_stop it=%0d obs=%h exp=%h", it, o, obs_t'(0));
            end
        end
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        bus.cfg_start_fw  = '0;
        bus.cfg_stop_fw   = '0;
        bus.cfg_step_fw   = '0;
        bus.cfg_dwell     = '0;
        bus.cfg_ch2_phase = '0;
        test_reset();
        test_tone();
        test_ch2_offset();
        test_sweep_profile();
        test_dwell0();
        test_degenerate();
        test_overflow();
        test_start_stop_same();
        test_start_in_run();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/dac_sweep_ctrl.md
Name: dac_sweep_ctrl

Overview:
- Dual-channel DDS sequencer that generates the sine-ROM read addresses for both AD9767 channels from 32-bit phase accumulators.
- Runs a stepped frequency sweep: start word, stop word, step, and dwell time per step.
- Channel 2 tracks channel 1 at a programmable phase offset.
- Sits between the control/config logic and the sine ROMs in the 125 MHz DAC clock domain; replaces the free-running address counter.

Parameters:
- PHASE_W, 32, phase accumulator and frequency-word width.
- ADDR_W, 10, ROM address width. Top ADDR_W bits of each accumulator.
- DWELL_W, 16, dwell counter width.

Ports:
- clk  in  1  DAC clock (125 MHz PLL output).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE.
- stop  in  1  one-cycle pulse; aborts to IDLE.
- cfg_start_fw  in  PHASE_W  first frequency word.
- cfg_stop_fw  in  PHASE_W  final frequency word.
- cfg_step_fw  in  PHASE_W  increment applied per dwell period.
- cfg_dwell  in  DWELL_W  clocks per step.
- cfg_ch2_phase  in  PHASE_W  channel-2 phase offset added at start.
- busy  out  1  high while in RUN.
- addr_valid  out  1  ch1_addr/ch2_addr carry live waveform data.
- sweep_done  out  1  one-cycle pulse at each sweep endpoint.
- cur_fw  out  PHASE_W  frequency word currently applied.
- ch1_addr  out  ADDR_W  ROM address, channel 1.
- ch2_addr  out  ADDR_W  ROM address, channel 2.

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- Reset: state=IDLE, acc1=acc2=0, cur_fw=0, dwell_cnt=0, all outputs 0.
- States: IDLE and RUN.
- IDLE:
  - Accumulators, addresses and cur_fw are held at 0; busy=0; addr_valid=0.
  - On start (and no stop in the same cycle), latch all cfg_* into shadow registers.
  - Set cur_fw<=cfg_start_fw, acc1<=0, acc2<=cfg_ch2_phase, dwell_cnt<=0, state<=RUN.
  - cfg_* changes after that cycle have no effect until the next start.
- RUN, every cycle:
  - acc1<=acc1+cur_fw and acc2<=acc2+cur_fw, modulo 2^PHASE_W.
  - ch1_addr/ch2_addr <= acc[PHASE_W-1 -: ADDR_W] (registered).
  - busy=1; addr_valid=1 from the first RUN cycle.
- Latency:
  - start sampled in cycle N, so busy=1 in N+1.
  - ch1_addr=0 and ch2_addr=offset top bits in N+1.
  - The first increment is visible in N+2.
- Dwell:
  - dwell_cnt counts 0..D-1, where D=max(cfg_dwell,1).
  - At D-1: dwell_cnt<=0 and a step occurs.
- Step (up direction):
  - nxt = cur_fw + step, computed at PHASE_W+1 bits.
  - If nxt >= stop_fw: endpoint reached, sweep_done=1 for one cycle, cur_fw<=start_fw (wrap, sawtooth sweep).
  - Otherwise cur_fw<=nxt.
- Degenerate configurations:
  - step=0 or start_fw>=stop_fw: cur_fw stays at start_fw (single tone), sweep_done never asserts.
  - Overflow of nxt past 2^PHASE_W is treated as an endpoint.
- stop:
  - Any state: next cycle state=IDLE, busy=0, addr_valid=0, addresses=0, cur_fw=0.
  - start and stop in the same cycle: stop wins.
  - start while in RUN is ignored.
- reset mid-sweep: identical to the reset values above on the next edge; no partial step is retained.

Optional Feature:
- Macro: DAC_SWEEP_BIDIR_EN.
- Defined: adds a direction bit (reset/start value = up).
  - Up: at the endpoint, cur_fw<=stop_fw, direction<=down, sweep_done pulses.
  - Down: nxt=cur_fw-step. If cur_fw-step <= start_fw, or it underflows, then cur_fw<=start_fw, direction<=up, sweep_done pulses.
  - Result is a triangle sweep with sweep_done at both ends.
- Undefined: sawtooth wrap as described above; no direction register.

Test Plan:
- Reset, then start with start_fw=0x0040_0000, step=0, dwell=4 → ch1_addr advances by 1 every clock (0,1,2…); wraps 1023→0 after 1024 clocks; sweep_done stays 0.
- Same as above with cfg_ch2_phase=0x4000_0000 → ch2_addr == ch1_addr+256 (mod 1024) every cycle.
- start_fw=0x100, stop_fw=0x400, step=0x100, dwell=3 → cur_fw sequence 0x100,0x200,0x300 with 3 clocks each, then sweep_done pulse and cur_fw=0x100.
- DAC_SWEEP_BIDIR_EN defined, same config → cur_fw sequence 0x100,0x200,0x300,0x400,0x300,0x200,0x100,0x200…; sweep_done at the 0x400 and 0x100 entries.
- start and stop asserted in the same IDLE cycle → remains IDLE, busy=0. stop mid-sweep → next cycle addr_valid=0, addresses=0, cur_fw=0.
- dwell=0, step=0x100 → step taken every clock (behaves as dwell=1). start_fw=0x500 > stop_fw=0x400 → constant cur_fw=0x500, no sweep_done.
